// File: rtl/hack_arith_pkg.sv
// Shared definitions for the HACK arithmetic datapath: FSM state encoding,
// default operand width and a constant clog2 for sizing counters.
package hack_arith_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder assembled from two half-adder cells and an OR for carry.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic w_s1;
  logic w_c1;
  logic w_c2;

  half_adder_cell u_ha0 (.a(a),    .b(b),   .s(w_s1), .c(w_c1));
  half_adder_cell u_ha1 (.a(w_s1), .b(cin), .s(s),    .c(w_c2));

  assign cout = w_c1 | w_c2;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell stepped LSB-first
// across WIDTH-bit operands, with start/done handshake.
module serial_add_ctrl
  import hack_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int unsigned CW = clog2(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_count;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_idle;
  logic             w_accept;
  logic             w_last;
  logic             w_fa_s;
  logic             w_fa_cout;
  logic [WIDTH-1:0] w_sum_next;

  full_adder_bit u_fa (
    .a   (r_a[0]),
    .b   (r_b[0]),
    .cin (r_carry),
    .s   (w_fa_s),
    .cout(w_fa_cout)
  );

  // The unused encoding 2'd3 behaves exactly like IDLE.
  assign w_idle     = (r_state != S_RUN) && (r_state != S_DONE);
  assign w_accept   = w_idle && start;
  assign w_last     = (r_state == S_RUN) && (r_count == CW'(WIDTH - 1));
  assign w_sum_next = {w_fa_s, r_sum[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_RUN:   w_next = w_last ? S_DONE : S_RUN;
      S_DONE:  w_next = S_IDLE;
      default: w_next = start ? S_RUN : S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub;
      r_count <= '0;
      r_sum   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_fa_cout;
      r_count <= r_count + CW'(1);
      r_sum   <= w_sum_next;
      if (w_last) begin
        // r_carry here is the carry into the MSB cell.
        r_cout <= w_fa_cout;
        r_ovf  <= r_carry ^ w_fa_cout;
        r_zero <= (w_sum_next == '0);
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=16).
module tb_serial_add_ctrl;
  logic        clk;
  logic        reset;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  int total = 0;
  int bad   = 0;

  serial_add_ctrl #(.WIDTH(16)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge while idle; returns #1 after the edge following done.
  task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                        input logic isub, input logic [15:0] es, input logic ec,
                        input logic eo, input logic ez);
    int n;
    a = ia; b = ib; sub = isub; start = 1'b1;
    tick();
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd16);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    chk({tag, "_zero"}, 32'(zero), 32'(ez));
    tick();
    chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
    chk({tag, "_hold_sum"}, 32'(sum), 32'(es));
  endtask

  initial begin
    int saw_done;
    int nz;
    int n;
    int busy_low;
    int dones;
    int done_at[$];

    reset = 1'b1; start = 1'b1; sub = 1'b0; a = 16'h0003; b = 16'h0004;
    saw_done = 0; nz = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) saw_done++;
      if (busy || sum != 0 || cout || ovf || zero) nz++;
    end
    chk("rst_no_done", 32'(saw_done), 32'd0);
    chk("rst_outputs_zero", 32'(nz), 32'd0);
    start = 1'b0;
    reset = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    run_op("add3p4",    16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0);
    run_op("addffffp1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("add7fffp1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("sub8000m1", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op("sub0m1",    16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    run_op("add1234",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    run_op("sub5m5",    16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Abort at RUN count 7; previous op left cout=1, zero=1.
    a = 16'hFFFF; b = 16'h0000; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("abort_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_zero", 32'(zero), 32'd0);
    tick();
    reset = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) saw_done++;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);

    // Start pulsed mid-RUN with other operands must be ignored.
    a = 16'h0003; b = 16'h0004; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("ign_lat", 32'(n), 32'd10);
    chk("ign_sum", 32'(sum), 32'h0007);
    tick();
    chk("ign_idle", 32'(busy), 32'd0);

    // Start held high: accepts at E0, E18, E36.
    a = 16'h0001; b = 16'h0002; sub = 1'b0; start = 1'b1;
    tick();
    busy_low = 0; dones = 0;
    for (int k = 1; k <= 52; k++) begin
      tick();
      if (!busy) busy_low++;
      if (done) begin
        dones++;
        done_at.push_back(k);
        chk("b2b_sum", 32'(sum), 32'h0003);
      end
    end
    start = 1'b0;
    chk("b2b_dones", 32'(dones), 32'd3);
    chk("b2b_busy_low", 32'(busy_low), 32'd5);
    if (done_at.size() == 3) begin
      chk("b2b_done0", 32'(done_at[0]), 32'd16);
      chk("b2b_done1", 32'(done_at[1]), 32'd34);
      chk("b2b_done2", 32'(done_at[2]), 32'd52);
    end
    tick();
    tick();
    chk("b2b_end_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded bound");
    $fatal(1);
  end
endmodule
